// File: rtl/spi_controller_if.sv
// SPI slave control bundle: conditioned SPI events in, datapath strobes out.
// The master side produces the events; the slave side is the controller.
interface spi_controller_if;
    logic cs_n;
    logic sclk_rise;
    logic sclk_fall;
    logic rw_bit;
    logic sr_load;
    logic addr_we;
    logic dm_we;
    logic miso_en;
    logic busy;

    modport master (
        output cs_n, sclk_rise, sclk_fall, rw_bit,
        input  sr_load, addr_we, dm_we, miso_en, busy
    );

    modport slave (
        input  cs_n, sclk_rise, sclk_fall, rw_bit,
        output sr_load, addr_we, dm_we, miso_en, busy
    );
endinterface

// File: rtl/spi_controller.sv
// SPI slave transaction sequencer: gathers the address byte, decodes R/W and
// steers the shift register, address latch, data memory and MISO buffer.
module spi_controller #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_controller_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        DECODE,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_COMMIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sr_load_q, sr_load_d;
    logic          addr_we_q, addr_we_d;
    logic          dm_we_q, dm_we_d;
    logic          miso_en_q, miso_en_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.cs_n) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                if (bus.sclk_rise) begin
                    if (cnt_q == LAST) state_d = DECODE;
                    else               cnt_d   = cnt_q + CW'(1);
                end
            end
            DECODE: begin
                state_d = bus.rw_bit ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: begin
                state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
                if (bus.sclk_fall) begin
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + CW'(1);
                end
            end
            WRITE_GET: begin
                if (bus.sclk_rise) begin
                    if (cnt_q == LAST) state_d = WRITE_COMMIT;
                    else               cnt_d   = cnt_q + CW'(1);
                end
            end
            WRITE_COMMIT: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deselect wins over any edge pulse seen in the same cycle.
        if (bus.cs_n) state_d = IDLE;
        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so they appear in the first cycle of it.
        sr_load_d = (state_d == READ_LOAD);
        addr_we_d = (state_d == DECODE);
        dm_we_d   = (state_d == WRITE_COMMIT);
        miso_en_d = (state_d == READ_SHIFT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_load_q <= 1'b0;
            addr_we_q <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_load_q <= sr_load_d;
            addr_we_q <= addr_we_d;
            dm_we_q   <= dm_we_d;
            miso_en_q <= miso_en_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sr_load = sr_load_q;
    assign bus.addr_we = addr_we_q;
    assign bus.dm_we   = dm_we_q;
    assign bus.miso_en = miso_en_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_controller;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if bus();

    spi_controller #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    endtask

    // Model: a transaction is a timeline of cycle indices k since selection.
    // addr_end = cycle of the W-th address rise, data_end = cycle of the W-th data pulse.
    int k = -1, addr_end = -1, data_end = -1, rc = 0, dc = 0;
    bit is_read = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = -1;
            started = 1'b1;
        end else if (k < 0) begin
            if (!bus.cs_n) begin
                k = 0; addr_end = -1; data_end = -1; rc = 0; dc = 0; is_read = 1'b0;
            end
        end else if (bus.cs_n) begin
            k = -1;
        end else begin
            if (addr_end < 0) begin
                if (bus.sclk_rise) begin
                    rc++;
                    if (rc == W) addr_end = k;
                end
            end else if (k == addr_end + 1) begin
                is_read = bus.rw_bit;
            end else if (data_end < 0) begin
                if (is_read ? (k >= addr_end + 3 && bus.sclk_fall)
                            : (k >= addr_end + 2 && bus.sclk_rise)) begin
                    dc++;
                    if (dc == W) data_end = k;
                end
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy",    bus.busy,    k >= 0);
            check("addr_we", bus.addr_we, k >= 0 && addr_end >= 0 && k == addr_end + 1);
            check("sr_load", bus.sr_load, k >= 0 && addr_end >= 0 && is_read && k == addr_end + 2);
            check("miso_en", bus.miso_en, k >= 0 && addr_end >= 0 && is_read && k >= addr_end + 3
                                          && (data_end < 0 || k <= data_end));
            check("dm_we",   bus.dm_we,   k >= 0 && data_end >= 0 && !is_read && k == data_end + 1);
        end
    end

    // Inputs are applied 2 time units after an edge and consumed by the next edge.
    task automatic tick(input bit cs, input bit r, input bit f, input bit rw);
        bus.cs_n = cs; bus.sclk_rise = r; bus.sclk_fall = f; bus.rw_bit = rw;
        @(posedge clk);
        #2;
    endtask

    task automatic pulses(input int n, input bit r, input bit f, input bit gap_fall);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, gap_fall, 1'b0);
            tick(1'b0, r, f, 1'b0);
        end
    endtask

    initial begin
        bus.cs_n = 1'b1; bus.sclk_rise = 1'b0; bus.sclk_fall = 1'b0; bus.rw_bit = 1'b0;
        #2;
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_miso", bus.miso_en, 1'b0);
        rst_n = 1'b1;

        // Write transaction
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("wr_select_busy", bus.busy, 1'b1);
        pulses(W, 1'b1, 1'b0, 1'b0);
        check("wr_addr_we", bus.addr_we, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("wr_addr_we_drop", bus.addr_we, 1'b0);
        check("wr_no_sr_load", bus.sr_load, 1'b0);
        pulses(W - 1, 1'b1, 1'b0, 1'b0);
        check("wr_dm_we_early", bus.dm_we, 1'b0);
        pulses(1, 1'b1, 1'b0, 1'b0);
        check("wr_dm_we", bus.dm_we, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_dm_we_drop", bus.dm_we, 1'b0);
        check("wr_done_busy", bus.busy, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("wr_idle_busy", bus.busy, 1'b0);

        // Read, then reset after 3 falls, then a fresh read
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(W, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("rd_sr_load", bus.sr_load, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("rd_miso_on", bus.miso_en, 1'b1);
        pulses(3, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_miso", bus.miso_en, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(W, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(W - 1, 1'b0, 1'b1, 1'b0);
        check("rd_miso_7", bus.miso_en, 1'b1);
        pulses(1, 1'b0, 1'b1, 1'b0);
        check("rd_miso_8", bus.miso_en, 1'b0);
        check("rd_done_busy", bus.busy, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after 4 address rises
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(4, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_busy", bus.busy, 1'b0);

        // Deselect coincident with the last address rise
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(W - 1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("coinc_addr_we", bus.addr_we, 1'b0);
        check("coinc_busy", bus.busy, 1'b0);

        // Falls interleaved with address rises do not count
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(W - 1, 1'b1, 1'b0, 1'b1);
        pulses(3, 1'b0, 1'b1, 1'b0);
        check("falls_ignored", bus.addr_we, 1'b0);
        pulses(1, 1'b1, 1'b0, 1'b0);
        check("falls_decode", bus.addr_we, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int len;
            len = $urandom_range(10, 60);
            for (int c = 0; c < len; c++) begin
                bit r, f;
                r = ($urandom % 3) == 0;
                f = !r && (($urandom % 3) == 0);
                rst_n = ($urandom % 400) != 0;
                tick(1'b0, r, f, 1'($urandom % 2));
            end
            rst_n = 1'b1;
            repeat ($urandom_range(1, 3)) tick(1'b1, 1'($urandom % 2), 1'b0, 1'b0);
        end

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
